// File: rtl/lcd_req_arbiter.sv
// Two-host arbiter in front of a single lcd_ctrl engine.
// Define LCD_ARB_FIXED_PRIO_EN for fixed host0 priority.
module lcd_req_arbiter #(
  parameter int IMG_SIZE = 36,
  parameter int WIN_SIZE = 9,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_cmd,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  output logic       req0_data_rd,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  input  logic [2:0] req1_cmd,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       req1_data_rd,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  input  logic       lcd_busy,
  input  logic [7:0] lcd_dataout,
  input  logic       lcd_output_valid,
  output logic       err
);

  localparam int SW = $clog2(IMG_SIZE);
  localparam int WW = $clog2(TIMEOUT);
  localparam int BW = $clog2(WIN_SIZE + 2);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STREAM,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          owner;
  logic [2:0]    cmd;
  logic          last_grant;
  logic [SW-1:0] scnt;
  logic [WW-1:0] wcnt;
  logic          seen_busy;
  logic [BW-1:0] beats;
  logic [BW:0]   beat_sum;
  logic          pick;
  logic [2:0]    pick_cmd;
  logic          any_req;
  logic          cmd_ok;
  logic          last_byte;
  logic          done;
  logic          tout;
  logic          route0;
  logic          route1;

  assign any_req = req0_valid | req1_valid;

`ifdef LCD_ARB_FIXED_PRIO_EN
  assign pick = ~req0_valid;
`else
  assign pick = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
`endif

  assign pick_cmd  = pick ? req1_cmd : req0_cmd;
  assign cmd_ok    = (cmd <= 3'd5);
  assign last_byte = (scnt == SW'(IMG_SIZE - 1));
  assign done      = ~lcd_busy & seen_busy;
  assign tout      = (wcnt == WW'(TIMEOUT - 1));
  assign beat_sum  = {1'b0, beats} + {{BW{1'b0}}, lcd_output_valid};
  assign route0    = lcd_output_valid & (state != IDLE) & ~owner;
  assign route1    = lcd_output_valid & (state != IDLE) & owner;

  // Next state and handshake/stream outputs
  always_comb begin
    state_nx      = state;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    req0_data_rd  = 1'b0;
    req1_data_rd  = 1'b0;
    lcd_cmd_valid = 1'b0;
    lcd_datain    = '0;
    unique case (state)
      IDLE: begin
        if (!lcd_busy && any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        req0_ready = ~owner;
        req1_ready = owner;
        if (cmd_ok) begin
          lcd_cmd_valid = 1'b1;
          state_nx = (cmd == 3'd1) ? STREAM : WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      STREAM: begin
        lcd_datain   = owner ? req1_data : req0_data;
        req0_data_rd = ~owner;
        req1_data_rd = owner;
        if (last_byte) state_nx = WAIT;
      end
      WAIT: begin
        if (done || tout) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant, counters, completion tracking and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cmd        <= '0;
      lcd_cmd    <= '0;
      last_grant <= 1'b1;
      scnt       <= '0;
      wcnt       <= '0;
      seen_busy  <= 1'b0;
      beats      <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == ISSUE) begin
        owner     <= pick;
        cmd       <= pick_cmd;
        scnt      <= '0;
        wcnt      <= '0;
        seen_busy <= 1'b0;
        beats     <= '0;
        if (pick_cmd <= 3'd5) lcd_cmd <= pick_cmd;
      end
      if (state == STREAM) scnt <= scnt + 1'b1;
      if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
        if (lcd_busy) seen_busy <= 1'b1;
      end
      if (state != IDLE && lcd_output_valid && beats != '1)
        beats <= beats + 1'b1;
      if (state == ISSUE && !cmd_ok) err <= 1'b1;
      if (state == WAIT && done) begin
        last_grant <= owner;
        if (cmd != 3'd1 && beat_sum != (BW + 1)'(WIN_SIZE))
          err <= 1'b1;
      end
      if (state == WAIT && !done && tout) err <= 1'b1;
      if (state == IDLE && lcd_output_valid) err <= 1'b1;
    end
  end

  // Output beats, delayed one cycle, to the current owner only
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= route0;
      rsp0_data  <= route0 ? lcd_dataout : '0;
      rsp1_valid <= route1;
      rsp1_data  <= route1 ? lcd_dataout : '0;
    end
  end

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Randomized bench for lcd_req_arbiter with a transaction-level
// host/lcd model; honours LCD_ARB_FIXED_PRIO_EN.
module tb_lcd_req_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [2:0] req0_cmd = '0;
  logic [7:0] req0_data = '0;
  logic       req1_valid = 1'b0;
  logic [2:0] req1_cmd = '0;
  logic [7:0] req1_data = '0;
  logic       lcd_busy = 1'b0;
  logic [7:0] lcd_dataout = '0;
  logic       lcd_output_valid = 1'b0;
  logic       req0_ready, req0_data_rd, rsp0_valid;
  logic [7:0] rsp0_data;
  logic       req1_ready, req1_data_rd, rsp1_valid;
  logic [7:0] rsp1_data;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic       err;

  always #5 clk = ~clk;

  lcd_req_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req0_data_rd(req0_data_rd), .rsp0_valid(rsp0_valid),
    .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .req1_data_rd(req1_data_rd), .rsp1_valid(rsp1_valid),
    .rsp1_data(rsp1_data),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .lcd_datain(lcd_datain), .lcd_busy(lcd_busy),
    .lcd_dataout(lcd_dataout),
    .lcd_output_valid(lcd_output_valid), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       s_rst = 1'b1;
  logic       s_v [2];
  logic [2:0] s_c [2];
  logic [7:0] s_d [2];
  logic       s_busy = 1'b0;
  logic       s_ov = 1'b0;
  logic [7:0] s_do = '0;

  int         cur_owner = -1;
  logic       nx_v [2];
  logic [7:0] nx_d [2];
  logic       err_exp = 1'b0;
  logic       lg = 1'b1;
  logic       pend [2];
  logic [2:0] pc [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want,
               $time);
    end
  endtask

  // One cycle: drive at negedge, check registered outputs, advance model
  task automatic step();
    @(negedge clk);
    reset            = s_rst;
    req0_valid       = s_v[0];
    req0_cmd         = s_c[0];
    req0_data        = s_d[0];
    req1_valid       = s_v[1];
    req1_cmd         = s_c[1];
    req1_data        = s_d[1];
    lcd_busy         = s_busy;
    lcd_output_valid = s_ov;
    lcd_dataout      = s_do;
    #1;
    chk("rsp0_valid", rsp0_valid, nx_v[0]);
    if (nx_v[0]) chk("rsp0_data", rsp0_data, nx_d[0]);
    chk("rsp1_valid", rsp1_valid, nx_v[1]);
    if (nx_v[1]) chk("rsp1_data", rsp1_data, nx_d[1]);
    chk("err", err, err_exp);
    for (int h = 0; h < 2; h++) begin
      nx_v[h] = !s_rst && s_ov && (cur_owner == h);
      nx_d[h] = s_do;
    end
    if (s_rst) err_exp = 1'b0;
    else if (s_ov && cur_owner < 0) err_exp = 1'b1;
  endtask

  task automatic chk_quiet();
    chk("ready", {req1_ready, req0_ready}, 0);
    chk("cmd_valid", lcd_cmd_valid, 0);
    chk("data_rd", {req1_data_rd, req0_data_rd}, 0);
    chk("datain", lcd_datain, 0);
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    s_busy = 1'b0;
    s_ov = 1'b0;
    cur_owner = -1;
    step();
    s_rst = 1'b0;
    lg = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    step();
    chk_quiet();
    chk("lcd_cmd_rst", lcd_cmd, 0);
  endtask

  // Serve the next pending host from IDLE back to IDLE
  task automatic serve(input bit tmo, input int nb, input bit ramp);
    int w;
    int hi;
    int pre;
    logic [2:0] c;
    logic [7:0] b;
`ifdef LCD_ARB_FIXED_PRIO_EN
    if (pend[0] && pend[1]) w = 0;
`else
    if (pend[0] && pend[1]) w = lg ? 0 : 1;
`endif
    else w = pend[0] ? 0 : 1;
    c = pc[w];
    cur_owner = -1;
    s_ov = 1'b0;
    pre = $urandom_range(0, 2);
    for (int i = 0; i < pre; i++) begin
      s_busy = 1'b1;
      step();
      chk_quiet();
    end
    s_busy = 1'b0;
    step();
    chk_quiet();
    cur_owner = w;
    step();
    chk("ready_grant", {req1_ready, req0_ready}, (w == 1) ? 2 : 1);
    chk("cmd_valid_issue", lcd_cmd_valid, c <= 3'd5);
    if (c <= 3'd5) chk("lcd_cmd", lcd_cmd, c);
    chk("data_rd_issue", {req1_data_rd, req0_data_rd}, 0);
    s_v[w] = 1'b0;
    pend[w] = 1'b0;
    if (c > 3'd5) begin
      err_exp = 1'b1;
      cur_owner = -1;
      return;
    end
    if (c == 3'd1) begin
      s_busy = 1'b1;
      for (int k = 0; k < 36; k++) begin
        b = ramp ? 8'(k) : 8'($urandom);
        s_d[w] = b;
        s_d[1-w] = 8'($urandom);
        step();
        chk("datain", lcd_datain, b);
        chk("data_rd", {req1_data_rd, req0_data_rd}, (w == 1) ? 2 : 1);
        chk("ready_stream", {req1_ready, req0_ready}, 0);
        chk("cmd_valid_stream", lcd_cmd_valid, 0);
      end
    end
    if (tmo) begin
      s_busy = 1'b0;
      for (int j = 0; j < 64; j++) begin
        step();
        chk_quiet();
      end
      err_exp = 1'b1;
      cur_owner = -1;
      return;
    end
    hi = nb + $urandom_range(1, 3);
    for (int j = 0; j < hi; j++) begin
      s_busy = 1'b1;
      s_ov = (j < nb);
      s_do = 8'($urandom);
      step();
      chk_quiet();
    end
    s_busy = 1'b0;
    s_ov = 1'b0;
    step();
    chk_quiet();
    if (c != 3'd1 && nb != 9) err_exp = 1'b1;
    lg = (w == 1);
    cur_owner = -1;
  endtask

  task automatic post(input int h, input logic [2:0] c);
    pend[h] = 1'b1;
    pc[h] = c;
    s_v[h] = 1'b1;
    s_c[h] = c;
  endtask

  initial begin
    logic [1:0] r;
    bit tmo;
    int nb;
    for (int h = 0; h < 2; h++) begin
      s_v[h] = 1'b0;
      s_c[h] = '0;
      s_d[h] = '0;
      nx_v[h] = 1'b0;
      nx_d[h] = '0;
      pend[h] = 1'b0;
      pc[h] = '0;
    end
    step();
    do_reset();

    post(0, 3'd1);
    serve(0, 9, 1);

    post(0, 3'd2);
    post(1, 3'd4);
    serve(0, 9, 0);
    serve(0, 9, 0);
    post(0, 3'd2);
    post(1, 3'd4);
    serve(0, 9, 0);
    serve(0, 9, 0);

    post(1, 3'd0);
    serve(0, 9, 0);

    post(0, 3'd5);
    serve(1, 9, 0);

    do_reset();
    post(1, 3'd7);
    serve(0, 9, 0);
    step();
    do_reset();
    s_ov = 1'b1;
    s_do = 8'hA5;
    step();
    chk_quiet();
    s_ov = 1'b0;
    step();

    do_reset();
    post(0, 3'd1);
    step();
    cur_owner = 0;
    step();
    s_v[0] = 1'b0;
    s_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_d[0] = 8'(k);
      step();
      chk("datain_pre_rst", lcd_datain, k);
    end
    s_d[0] = 8'd10;
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    s_busy = 1'b0;
    cur_owner = -1;
    pend[0] = 1'b0;
    lg = 1'b1;
    step();
    chk_quiet();
    chk("lcd_cmd_midrst", lcd_cmd, 0);

    for (int rnd = 0; rnd < 150; rnd++) begin
      if (err_exp || $urandom_range(0, 5) == 0) do_reset();
      r = 2'($urandom_range(0, 3));
      if (r == 2'b00) begin
        s_ov = ($urandom_range(0, 3) == 0);
        s_do = 8'($urandom);
        cur_owner = -1;
        step();
        chk_quiet();
        s_ov = 1'b0;
      end else begin
        for (int h = 0; h < 2; h++)
          if (r[h])
            post(h, ($urandom_range(0, 9) == 0) ?
                    3'(6 + $urandom_range(0, 1)) :
                    3'($urandom_range(0, 5)));
        while (pend[0] || pend[1]) begin
          tmo = ($urandom_range(0, 15) == 0);
          nb = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 10) : 9;
          serve(tmo, nb, 0);
        end
      end
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
